// File: rtl/sha2_sigma_cfu.sv
// ---------------------------------------------------------------------------
// sha2_sigma_cfu
//
// SHA-2 sigma unit for a custom-function-unit slot. It computes one of the
// four SHA-2 mixing functions on rs1:
//   func[1:0] = 0 : Sigma0 (big, compression round on 'a')
//   func[1:0] = 1 : Sigma1 (big, compression round on 'e')
//   func[1:0] = 2 : sigma0 (small, message schedule)
//   func[1:0] = 3 : sigma1 (small, message schedule)
// XLEN selects the SHA-256 (32) or SHA-512 (64) rotate/shift amounts.
// Setting func[2] is illegal. The request still takes a slot and returns in
// order, with status 1 and data 0.
//
// The unit accepts one request per cycle. A fixed-latency pipeline of
// PIPE_STAGES cycles feeds a first-word-fall-through response FIFO. An
// occupancy counter covers everything in flight plus everything queued. That
// counter alone gates req_ready, so the pipeline never has to stall and the
// FIFO can never overflow.
//
// Parameters
//   XLEN         operand width, 32 or 64
//   PIPE_STAGES  accept-to-resp_valid latency in cycles (>= 1)
//   FIFO_DEPTH   max outstanding requests, power of 2, >= PIPE_STAGES
//   ID_W         width of the request/response tag
//
// Ports
//   clk          in   clock
//   rst          in   synchronous reset, active low
//   req_valid    in   request valid
//   req_ready    out  request ready (registered state only)
//   req_id       in   request tag, echoed on resp_id
//   req_func     in   function select, [2] must be 0
//   rs1          in   operand x
//   rs2          in   unused second operand
//   resp_valid   out  response valid
//   resp_ready   in   response ready
//   resp_id      out  tag of the returned request
//   resp_status  out  0 = ok, 1 = illegal function
//   resp_data    out  result
// ---------------------------------------------------------------------------
module sha2_sigma_cfu #(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ID_W-1:0] req_id,
    input  logic [2:0]      req_func,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [ID_W-1:0] resp_id,
    output logic            resp_status,
    output logic [XLEN-1:0] resp_data
);

    // Rotate/shift amounts. SHA-256 values apply unless XLEN is 64.
    localparam bit WIDE = (XLEN == 64);
    localparam int SUM0_R1 = WIDE ? 28 : 2;
    localparam int SUM0_R2 = WIDE ? 34 : 13;
    localparam int SUM0_R3 = WIDE ? 39 : 22;
    localparam int SUM1_R1 = WIDE ? 14 : 6;
    localparam int SUM1_R2 = WIDE ? 18 : 11;
    localparam int SUM1_R3 = WIDE ? 41 : 25;
    localparam int SIG0_R1 = WIDE ? 1  : 7;
    localparam int SIG0_R2 = WIDE ? 8  : 18;
    localparam int SIG0_SH = WIDE ? 7  : 3;
    localparam int SIG1_R1 = WIDE ? 19 : 17;
    localparam int SIG1_R2 = WIDE ? 61 : 19;
    localparam int SIG1_SH = WIDE ? 6  : 10;

    // cnt must reach FIFO_DEPTH itself, so it needs one more state than a pointer.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] x, input int n);
        return (x >> n) | (x << (XLEN - n));
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic            accept;
    logic            xfer;
    logic            run_q;
    logic [CNT_W-1:0] occ;

    logic [XLEN-1:0] calc_data;
    logic            calc_status;

    logic            wr_valid;
    logic [ID_W-1:0] wr_id;
    logic            wr_status;
    logic [XLEN-1:0] wr_data;

    logic [ID_W-1:0] id_mem   [FIFO_DEPTH];
    logic            st_mem   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    // rs2 is part of the CFU port set but no sigma function reads it.
    logic unused_rs2;
    assign unused_rs2 = ^rs2;

    assign accept = req_valid & req_ready;
    assign xfer   = resp_valid & resp_ready;

    // Sigma datapath. Illegal functions produce zero data and set the status bit.
    always_comb begin
        calc_data   = '0;
        calc_status = 1'b0;
        if (req_func[2]) begin
            calc_status = 1'b1;
        end else begin
            case (req_func[1:0])
                2'd0: calc_data = ror(rs1, SUM0_R1) ^ ror(rs1, SUM0_R2) ^ ror(rs1, SUM0_R3);
                2'd1: calc_data = ror(rs1, SUM1_R1) ^ ror(rs1, SUM1_R2) ^ ror(rs1, SUM1_R3);
                2'd2: calc_data = ror(rs1, SIG0_R1) ^ ror(rs1, SIG0_R2) ^ (rs1 >> SIG0_SH);
                2'd3: calc_data = ror(rs1, SIG1_R1) ^ ror(rs1, SIG1_R2) ^ (rs1 >> SIG1_SH);
            endcase
        end
    end

    // run_q holds req_ready low while reset is asserted and releases it one
    // cycle after reset goes away.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // occ counts requests in the pipe plus requests in the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ <= '0;
        end else begin
            case ({accept, xfer})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign req_ready = run_q && (occ != CNT_W'(FIFO_DEPTH));

    // Pipeline. With one stage, the computed result goes straight into the
    // FIFO at the accept edge. Deeper settings insert PIPE_STAGES-1 register
    // stages ahead of the FIFO write.
    generate
        if (PIPE_STAGES == 1) begin : g_direct
            assign wr_valid  = accept;
            assign wr_id     = req_id;
            assign wr_status = calc_status;
            assign wr_data   = calc_data;
        end else begin : g_pipe
            localparam int N = PIPE_STAGES - 1;
            logic            v_q  [N];
            logic [ID_W-1:0] id_q [N];
            logic            st_q [N];
            logic [XLEN-1:0] d_q  [N];

            // Shift register of valid/tag/status/data. Reset drops anything in flight.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < N; i++) begin
                        v_q[i]  <= 1'b0;
                        id_q[i] <= '0;
                        st_q[i] <= 1'b0;
                        d_q[i]  <= '0;
                    end
                end else begin
                    v_q[0]  <= accept;
                    id_q[0] <= req_id;
                    st_q[0] <= calc_status;
                    d_q[0]  <= calc_data;
                    for (int i = 1; i < N; i++) begin
                        v_q[i]  <= v_q[i-1];
                        id_q[i] <= id_q[i-1];
                        st_q[i] <= st_q[i-1];
                        d_q[i]  <= d_q[i-1];
                    end
                end
            end

            assign wr_valid  = v_q[N-1];
            assign wr_id     = id_q[N-1];
            assign wr_status = st_q[N-1];
            assign wr_data   = d_q[N-1];
        end
    endgenerate

    // Response FIFO storage. It has no reset because the outputs are masked
    // whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            id_mem[wr_ptr]   <= wr_id;
            st_mem[wr_ptr]   <= wr_status;
            data_mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_valid) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (xfer) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_valid, xfer})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // The head entry falls through to the outputs. It stays stable until it
    // is transferred, and it reads as zero when the FIFO is empty.
    assign resp_valid  = (fifo_cnt != '0);
    assign resp_id     = resp_valid ? id_mem[rd_ptr]   : '0;
    assign resp_status = resp_valid ? st_mem[rd_ptr]   : 1'b0;
    assign resp_data   = resp_valid ? data_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sha2_sigma_cfu.sv
// ---------------------------------------------------------------------------
// tb_sha2_sigma_cfu
//
// Directed bench with three instances that share the request-side inputs:
//   a : XLEN=32, PIPE_STAGES=1, FIFO_DEPTH=4
//   b : XLEN=32, PIPE_STAGES=3, FIFO_DEPTH=4
//   c : XLEN=64, PIPE_STAGES=1, FIFO_DEPTH=4
// 'sel' picks which instance the checks observe. Expected values are
// hand-computed from the sigma rotate/shift definitions.
// ---------------------------------------------------------------------------
module tb_sha2_sigma_cfu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_id;
    logic [2:0]  req_func;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        resp_ready;

    logic        a_req_ready, a_resp_valid, a_resp_status;
    logic [3:0]  a_resp_id;
    logic [31:0] a_resp_data;
    logic        b_req_ready, b_resp_valid, b_resp_status;
    logic [3:0]  b_resp_id;
    logic [31:0] b_resp_data;
    logic        c_req_ready, c_resp_valid, c_resp_status;
    logic [3:0]  c_resp_id;
    logic [63:0] c_resp_data;

    int sel   = 0;
    int total = 0;
    int bad   = 0;

    // Sigma functions of x=1 with func 0..3.
    logic [63:0] exp32 [4] = '{64'h40080400, 64'h04200080, 64'h02004000, 64'h0000a000};
    logic [63:0] exp64 [4] = '{64'h0000001042000000, 64'h0004400000800000,
                               64'h8100000000000000, 64'h0000200000000008};

    always #5 clk = ~clk;

    sha2_sigma_cfu #(.XLEN(32), .PIPE_STAGES(1), .FIFO_DEPTH(4), .ID_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_id(req_id),
        .req_func(req_func), .rs1(rs1[31:0]), .rs2(rs2[31:0]),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_id(a_resp_id),
        .resp_status(a_resp_status), .resp_data(a_resp_data)
    );

    sha2_sigma_cfu #(.XLEN(32), .PIPE_STAGES(3), .FIFO_DEPTH(4), .ID_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_id(req_id),
        .req_func(req_func), .rs1(rs1[31:0]), .rs2(rs2[31:0]),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_id(b_resp_id),
        .resp_status(b_resp_status), .resp_data(b_resp_data)
    );

    sha2_sigma_cfu #(.XLEN(64), .PIPE_STAGES(1), .FIFO_DEPTH(4), .ID_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(c_req_ready), .req_id(req_id),
        .req_func(req_func), .rs1(rs1), .rs2(rs2),
        .resp_valid(c_resp_valid), .resp_ready(resp_ready), .resp_id(c_resp_id),
        .resp_status(c_resp_status), .resp_data(c_resp_data)
    );

    function automatic logic f_valid();
        case (sel)
            0:       return a_resp_valid;
            1:       return b_resp_valid;
            default: return c_resp_valid;
        endcase
    endfunction

    function automatic logic f_ready();
        case (sel)
            0:       return a_req_ready;
            1:       return b_req_ready;
            default: return c_req_ready;
        endcase
    endfunction

    function automatic logic [3:0] f_id();
        case (sel)
            0:       return a_resp_id;
            1:       return b_resp_id;
            default: return c_resp_id;
        endcase
    endfunction

    function automatic logic f_status();
        case (sel)
            0:       return a_resp_status;
            1:       return b_resp_status;
            default: return c_resp_status;
        endcase
    endfunction

    function automatic logic [63:0] f_data();
        case (sel)
            0:       return {32'h0, a_resp_data};
            1:       return {32'h0, b_resp_data};
            default: return c_resp_data;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] id, input logic [2:0] f,
                                 input logic [63:0] x);
        req_valid = v;
        req_id    = id;
        req_func  = f;
        rs1       = x;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        resp_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Wait a bounded number of cycles for the selected instance to present a response.
    task automatic waitValid(input string tag);
        int n = 0;
        while (!f_valid() && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, f_valid(), 1);
    endtask

    // Bounded run so a hung design still ends the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rs2 = 64'h0123456789abcdef;
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        resp_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        // Reset state on every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            checkOutput("rst req_ready", f_ready(), 0);
            checkOutput("rst resp_valid", f_valid(), 0);
            checkOutput("rst resp_id", f_id(), 0);
            checkOutput("rst resp_status", f_status(), 0);
            checkOutput("rst resp_data", f_data(), 0);
        end
        rst = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            checkOutput("post-rst req_ready", f_ready(), 1);
        end

        // T1: single-cycle latency with the textbook SHA-256 round values.
        sel = 0;
        resp_ready = 1'b1;
        applyStimulus(1'b1, 4'd3, 3'd0, 64'h6a09e667);
        tick();
        checkOutput("t1 sum0 valid", f_valid(), 1);
        checkOutput("t1 sum0 id", f_id(), 3);
        checkOutput("t1 sum0 status", f_status(), 0);
        checkOutput("t1 sum0 data", f_data(), 64'hce20b47e);
        applyStimulus(1'b1, 4'd5, 3'd1, 64'h510e527f);
        tick();
        checkOutput("t1 sum1 valid", f_valid(), 1);
        checkOutput("t1 sum1 id", f_id(), 5);
        checkOutput("t1 sum1 data", f_data(), 64'h3587272b);
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        tick();
        checkOutput("t1 empty", f_valid(), 0);

        // T2: all four functions back to back, one response per cycle.
        doReset();
        sel = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 3'(i), 64'd1);
            tick();
            checkOutput("t2 valid", f_valid(), 1);
            checkOutput("t2 id", f_id(), 64'(i + 1));
            checkOutput("t2 data", f_data(), exp32[i]);
        end
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        tick();
        checkOutput("t2 empty", f_valid(), 0);

        // T3: three-stage pipe, fill to capacity with the consumer stalled.
        doReset();
        sel = 1;
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3 ready", f_ready(), 1);
            applyStimulus(1'b1, 4'(i + 1), 3'(i), 64'd1);
            tick();
            if (i == 1) checkOutput("t3 in-flight empty", f_valid(), 0);
            if (i == 2) checkOutput("t3 latency", f_valid(), 1);
        end
        checkOutput("t3 full", f_ready(), 0);
        applyStimulus(1'b1, 4'd5, 3'd0, 64'd1);
        tick();
        tick();
        checkOutput("t3 held ready", f_ready(), 0);
        checkOutput("t3 stable id", f_id(), 1);
        checkOutput("t3 stable data", f_data(), exp32[0]);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("t3 ready after xfer", f_ready(), 1);
        checkOutput("t3 head id", f_id(), 2);
        tick();
        checkOutput("t3 refull", f_ready(), 0);
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitValid("t3 drain valid");
            checkOutput("t3 drain id", f_id(), 64'(k + 2));
            checkOutput("t3 drain data", f_data(), (k == 3) ? exp32[0] : exp32[k + 1]);
            tick();
        end
        checkOutput("t3 drained", f_valid(), 0);

        // T4: an illegal function between two legal requests.
        doReset();
        sel = 0;
        resp_ready = 1'b1;
        applyStimulus(1'b1, 4'd6, 3'd0, 64'd1);
        tick();
        checkOutput("t4 first id", f_id(), 6);
        checkOutput("t4 first status", f_status(), 0);
        checkOutput("t4 first data", f_data(), exp32[0]);
        applyStimulus(1'b1, 4'd7, 3'd4, 64'd1);
        tick();
        checkOutput("t4 illegal valid", f_valid(), 1);
        checkOutput("t4 illegal id", f_id(), 7);
        checkOutput("t4 illegal status", f_status(), 1);
        checkOutput("t4 illegal data", f_data(), 0);
        applyStimulus(1'b1, 4'd8, 3'd3, 64'd1);
        tick();
        checkOutput("t4 last id", f_id(), 8);
        checkOutput("t4 last status", f_status(), 0);
        checkOutput("t4 last data", f_data(), exp32[3]);
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        tick();

        // T5: SHA-512 amounts.
        doReset();
        sel = 2;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 3'(i), 64'd1);
            tick();
            checkOutput("t5 valid", f_valid(), 1);
            checkOutput("t5 id", f_id(), 64'(i + 1));
            checkOutput("t5 data", f_data(), exp64[i]);
        end
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        tick();

        // T6: reset with work both queued and in flight.
        doReset();
        sel = 1;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i + 10), 3'(i), 64'd1);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        checkOutput("t6 pre-reset valid", f_valid(), 1);
        rst = 1'b0;
        tick();
        checkOutput("t6 rst valid", f_valid(), 0);
        checkOutput("t6 rst ready", f_ready(), 0);
        checkOutput("t6 rst id", f_id(), 0);
        checkOutput("t6 rst data", f_data(), 0);
        rst = 1'b1;
        tick();
        checkOutput("t6 ready", f_ready(), 1);
        resp_ready = 1'b1;
        begin
            int stale = 0;
            for (int i = 0; i < 6; i++) begin
                if (f_valid()) stale++;
                tick();
            end
            checkOutput("t6 stale responses", 64'(stale), 0);
        end
        applyStimulus(1'b1, 4'd9, 3'd1, 64'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 3'd0, 64'd0);
        waitValid("t6 new valid");
        checkOutput("t6 new id", f_id(), 9);
        checkOutput("t6 new status", f_status(), 0);
        checkOutput("t6 new data", f_data(), exp32[1]);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
